// File: rtl/multdiv_sequencer.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) unit; build option MULTDIV_OVF_CHECK_EN.
// Latency: 33 cycles start edge to result edge, fixed for all operands; data_resultRDY pulses one cycle.
// Backpressure: none; starts are accepted only while idle (busy low), starts seen while busy are dropped.
module multdiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // acc/q form the {high, low} product for multiply and {remainder, dividend/quotient} for divide
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mag_x;
    logic             sign_a;
    logic             sign_b;
    logic             op_div;
    logic             b_zero;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             neg;
    logic [WIDTH-1:0] fix_result;
    logic             fix_exc;
`ifdef MULTDIV_OVF_CHECK_EN
    logic [2*WIDTH-1:0] prod_s;
`endif

    always_comb begin
        abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        mul_sum   = q[0] ? ({1'b0, acc} + {1'b0, mag_x}) : {1'b0, acc};
        div_shift = {acc, q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_x};
    end

    always_comb begin
        neg        = sign_a ^ sign_b;
        fix_result = '0;
        fix_exc    = 1'b0;
`ifdef MULTDIV_OVF_CHECK_EN
        prod_s     = neg ? -{acc, q} : {acc, q};
`endif
        if (op_div) begin
            if (b_zero) begin
                fix_result = '0;
                fix_exc    = 1'b1;
            end else begin
                fix_result = neg ? -q : q;
`ifdef MULTDIV_OVF_CHECK_EN
                // an unsigned quotient >= 2^31 with positive sign only arises from -2^31 / -1
                fix_exc    = q[WIDTH-1] & ~neg;
`endif
            end
        end else begin
`ifdef MULTDIV_OVF_CHECK_EN
            fix_result = prod_s[WIDTH-1:0];
            fix_exc    = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
`else
            fix_result = neg ? -q : q;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            q              <= '0;
            mag_x          <= '0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            op_div         <= 1'b0;
            b_zero         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        op_div <= ~ctrl_MULT;
                        sign_a <= data_operandA[WIDTH-1];
                        sign_b <= data_operandB[WIDTH-1];
                        b_zero <= (data_operandB == '0);
                        mag_x  <= ctrl_MULT ? abs_a : abs_b;
                        q      <= ctrl_MULT ? abs_b : abs_a;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (op_div) begin
                        acc <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], ~div_trial[WIDTH]};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        q   <= {mul_sum[0], q[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    data_result    <= fix_result;
                    data_exception <= fix_exc;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: fixed-latency results, sign handling, divide by zero,
// dropped starts while busy, back-to-back start in the ready cycle and mid-operation reset.
module tb_multdiv_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULTDIV_OVF_CHECK_EN
    localparam logic OVF_EXC = 1'b1;
`else
    localparam logic OVF_EXC = 1'b0;
`endif

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start between edges; returns #1 after the sampling edge (E0).
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Waits for the ready pulse (bounded), checks latency, result, exception and pulse width.
    task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic exp_exc);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        while (n < 40 && !got) begin
            @(posedge clock);
            #1;
            n++;
            got = data_resultRDY;
        end
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_result"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        check({tag, "_rdy_single"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, "_result_held"}, data_result, exp_res);
    endtask

    initial begin
        int n;
        int pulses;
        bit got;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #23;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        wait_result("mul_7_m6", 32'hFFFF_FFD6, 1'b0);

        start(1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
        wait_result("mul_m7_m6", 32'd42, 1'b0);

        start(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_result("div_m100_7", 32'hFFFF_FFF2, 1'b0);

        start(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_result("div_100_m7", 32'hFFFF_FFF2, 1'b0);

        start(1'b0, 1'b1, 32'd7, 32'd100);
        wait_result("div_7_100", 32'd0, 1'b0);

        start(1'b0, 1'b1, 32'd5, 32'd0);
        wait_result("div_by_zero", 32'd0, 1'b1);

        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_result("mul_ovf", 32'd0, OVF_EXC);

        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_min_m1", 32'h8000_0000, OVF_EXC);

        start(1'b1, 1'b1, 32'd6, 32'd3);
        wait_result("both_ctrl_mul", 32'd18, 1'b0);

        // MULT 3 x 4 with a stray DIV 9 / 3 pulsed at cycle 10.
        start(1'b1, 1'b0, 32'd3, 32'd4);
        n      = 0;
        pulses = 0;
        got    = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 10) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd3;
            end else begin
                ctrl_DIV = 1'b0;
            end
            got = data_resultRDY;
        end
        check("ignore_latency", n, 32'd33);
        check("ignore_result", data_result, 32'd12);
        // Start DIV 9 / 3 in the ready cycle itself.
        start(1'b0, 1'b1, 32'd9, 32'd3);
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clock);
            #1;
            n++;
            if (data_resultRDY) pulses++;
            got = data_resultRDY;
        end
        check("b2b_latency", n, 32'd33);
        check("b2b_result", data_result, 32'd3);
        check("b2b_pulses", pulses, 32'd1);

        // Reset at cycle 15 of a DIV aborts it with no ready pulse.
        start(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_result", data_result, 32'd0);
        check("abort_exc", {31'd0, data_exception}, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        check("abort_no_rdy", pulses, 32'd0);

        start(1'b1, 1'b0, 32'd2, 32'd3);
        wait_result("post_reset_mul", 32'd6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
